// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, ALU control encodings, control bundle and instruction decoder
package decode_pkg;
  localparam logic [4:0] ZR = 5'd31;
  localparam logic [4:0] COND_LT = 5'b01011;
  localparam logic [9:0] OP_ADDI = 10'b1001000100;
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_EOR = 11'b11001010000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_LSR = 11'b11010011010;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [5:0] OP_B = 6'b000101;
  localparam logic [7:0] OP_BCOND = 8'b01010100;
  localparam logic [7:0] OP_CBZ = 8'b10110100;

  typedef enum logic [2:0] {
    ALU_PASSB = 3'b000,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b011,
    ALU_AND = 3'b100,
    ALU_XOR = 3'b110
  } aluop_e;

  typedef enum logic [1:0] {
    SRC_REG = 2'b00,
    SRC_IMM9 = 2'b01,
    SRC_IMM12 = 2'b10
  } alusrc_e;

  typedef struct packed {
    aluop_e aluop;
    alusrc_e alusrc;
    logic setflag;
    logic useshift;
    logic memwrite;
    logic memtoreg;
    logic regwrite;
    logic is_b;
    logic is_bcond;
    logic is_cbz;
  } ctrl_t;

  // Anything not recognised falls through as an all-zero bundle, i.e. a NOP.
  function automatic ctrl_t decode(input logic [31:0] i);
    ctrl_t c;
    c = '0;
    if (i[31:22] == OP_ADDI) begin
      c.aluop = ALU_ADD;
      c.alusrc = SRC_IMM12;
      c.regwrite = 1'b1;
    end else if (i[31:21] == OP_ADDS || i[31:21] == OP_SUBS) begin
      c.aluop = i[30] ? ALU_SUB : ALU_ADD;
      c.setflag = 1'b1;
      c.regwrite = 1'b1;
    end else if (i[31:21] == OP_AND || i[31:21] == OP_EOR) begin
      c.aluop = i[30] ? ALU_XOR : ALU_AND;
      c.regwrite = 1'b1;
    end else if (i[31:21] == OP_LSR) begin
      c.useshift = 1'b1;
      c.regwrite = 1'b1;
    end else if (i[31:21] == OP_LDUR || i[31:21] == OP_STUR) begin
      c.aluop = ALU_ADD;
      c.alusrc = SRC_IMM9;
      c.memtoreg = i[22];
      c.regwrite = i[22];
      c.memwrite = ~i[22];
    end else if (i[31:26] == OP_B) begin
      c.is_b = 1'b1;
    end else if (i[31:24] == OP_BCOND) begin
      c.is_bcond = 1'b1;
    end else if (i[31:24] == OP_CBZ) begin
      c.is_cbz = 1'b1;
    end
    return c;
  endfunction
endpackage

// File: rtl/regfile_32x64.sv
// regfile_32x64: 32x64 register file, X31 hardwired to zero, write-through bypass on reads
module regfile_32x64 import decode_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [63:0] i_wd,
  input  logic [4:0]  i_ra,
  input  logic [4:0]  i_rb,
  output logic [63:0] o_da,
  output logic [63:0] o_db
);
  logic [63:0] r_mem [32];

  // Storage update; X31 is never written so it stays at its reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 32; k++) r_mem[k] <= '0;
    end else if (i_we && i_wa != ZR) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign o_da = (i_ra == ZR) ? '0 : (i_we && i_wa == i_ra) ? i_wd : r_mem[i_ra];
  assign o_db = (i_rb == ZR) ? '0 : (i_we && i_wa == i_rb) ? i_wd : r_mem[i_rb];
endmodule

// File: rtl/decode_execute_slice.sv
// decode_execute_slice: decode, forwarding, branch resolve, ID/EX and EX/MEM registers (FLAG_BYPASS_EN lets B.LT see the EX-stage flags)
module decode_execute_slice import decode_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_if,
  input  logic [63:0] pc_if,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [63:0] wb_data,
  input  logic [63:0] alu_result_ex,
  input  logic [63:0] mem_fwd_data,
  input  logic        flag_n,
  input  logic        flag_v,
  input  logic        ex_n,
  input  logic        ex_v,
  output logic        br_taken,
  output logic [63:0] br_target,
  output logic [63:0] idex_data1,
  output logic [63:0] idex_data2,
  output logic [63:0] idex_imm9,
  output logic [63:0] idex_imm12,
  output logic [63:0] idex_wrdata,
  output logic [4:0]  idex_rd,
  output logic [1:0]  idex_alusrc,
  output logic [2:0]  idex_aluop,
  output logic [5:0]  idex_shamt,
  output logic        idex_setflag,
  output logic        idex_useshift,
  output logic        idex_memwrite,
  output logic        idex_memtoreg,
  output logic        idex_regwrite,
  output logic [63:0] exmem_result,
  output logic [63:0] exmem_wrdata,
  output logic [4:0]  exmem_rd,
  output logic        exmem_memwrite,
  output logic        exmem_memtoreg,
  output logic        exmem_regwrite
);
  ctrl_t       w_ctrl;
  logic [4:0]  w_rn, w_rb;
  logic [63:0] w_rf_a, w_rf_b, w_fa, w_fb, w_imm9, w_imm12, w_off26, w_off19;
  logic        w_n, w_v;

  assign w_ctrl = decode(instr_if);
  assign w_rn = instr_if[9:5];
  assign w_rb = (w_ctrl.memwrite | w_ctrl.is_cbz) ? instr_if[4:0] : instr_if[20:16];
  assign w_imm9 = {{55{instr_if[20]}}, instr_if[20:12]};
  assign w_imm12 = {52'd0, instr_if[21:10]};
  assign w_off26 = {{36{instr_if[25]}}, instr_if[25:0], 2'b00};
  assign w_off19 = {{43{instr_if[23]}}, instr_if[23:5], 2'b00};

  regfile_32x64 u_rf (
    .clk  (clk),
    .rst  (reset),
    .i_we (wb_en),
    .i_wa (wb_rd),
    .i_wd (wb_data),
    .i_ra (w_rn),
    .i_rb (w_rb),
    .o_da (w_rf_a),
    .o_db (w_rf_b)
  );

  assign w_fa = (w_rn != ZR && idex_regwrite && idex_rd == w_rn) ? alu_result_ex :
                (w_rn != ZR && exmem_regwrite && exmem_rd == w_rn) ? mem_fwd_data : w_rf_a;
  assign w_fb = (w_rb != ZR && idex_regwrite && idex_rd == w_rb) ? alu_result_ex :
                (w_rb != ZR && exmem_regwrite && exmem_rd == w_rb) ? mem_fwd_data : w_rf_b;

`ifdef FLAG_BYPASS_EN
  assign w_n = idex_setflag ? ex_n : flag_n;
  assign w_v = idex_setflag ? ex_v : flag_v;
`else
  logic w_unused_flags;
  assign w_n = flag_n;
  assign w_v = flag_v;
  assign w_unused_flags = ex_n ^ ex_v;
`endif

  assign br_taken = w_ctrl.is_b | (w_ctrl.is_cbz & ~|w_fb) |
                    (w_ctrl.is_bcond & (instr_if[4:0] == COND_LT) & (w_n ^ w_v));
  assign br_target = pc_if + (w_ctrl.is_b ? w_off26 : w_off19);

  // ID/EX capture of decoded controls and forwarded operands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_data1 <= '0;
      idex_data2 <= '0;
      idex_imm9 <= '0;
      idex_imm12 <= '0;
      idex_wrdata <= '0;
      idex_rd <= '0;
      idex_alusrc <= '0;
      idex_aluop <= '0;
      idex_shamt <= '0;
      idex_setflag <= 1'b0;
      idex_useshift <= 1'b0;
      idex_memwrite <= 1'b0;
      idex_memtoreg <= 1'b0;
      idex_regwrite <= 1'b0;
    end else begin
      idex_data1 <= w_fa;
      idex_data2 <= w_fb;
      idex_imm9 <= w_imm9;
      idex_imm12 <= w_imm12;
      idex_wrdata <= w_fb;
      idex_rd <= instr_if[4:0];
      idex_alusrc <= w_ctrl.alusrc;
      idex_aluop <= w_ctrl.aluop;
      idex_shamt <= w_ctrl.useshift ? instr_if[15:10] : '0;
      idex_setflag <= w_ctrl.setflag;
      idex_useshift <= w_ctrl.useshift;
      idex_memwrite <= w_ctrl.memwrite;
      idex_memtoreg <= w_ctrl.memtoreg;
      idex_regwrite <= w_ctrl.regwrite;
    end
  end

  // EX/MEM capture of the ALU result and the controls travelling with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exmem_result <= '0;
      exmem_wrdata <= '0;
      exmem_rd <= '0;
      exmem_memwrite <= 1'b0;
      exmem_memtoreg <= 1'b0;
      exmem_regwrite <= 1'b0;
    end else begin
      exmem_result <= alu_result_ex;
      exmem_wrdata <= idex_wrdata;
      exmem_rd <= idex_rd;
      exmem_memwrite <= idex_memwrite;
      exmem_memtoreg <= idex_memtoreg;
      exmem_regwrite <= idex_regwrite;
    end
  end
endmodule

// File: tb/tb_decode_execute_slice.sv
// tb_decode_execute_slice: directed vectors against an instruction-level model of the decode slice
module tb_decode_execute_slice;
  logic        clk = 1'b0, reset = 1'b0;
  logic [31:0] instr_if = '0;
  logic [63:0] pc_if = '0, wb_data = '0, alu_result_ex = '0, mem_fwd_data = '0;
  logic        wb_en = 1'b0, flag_n = 1'b0, flag_v = 1'b0, ex_n = 1'b0, ex_v = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic        br_taken;
  logic [63:0] br_target, idex_data1, idex_data2, idex_imm9, idex_imm12, idex_wrdata;
  logic [4:0]  idex_rd, exmem_rd;
  logic [1:0]  idex_alusrc;
  logic [2:0]  idex_aluop;
  logic [5:0]  idex_shamt;
  logic        idex_setflag, idex_useshift, idex_memwrite, idex_memtoreg, idex_regwrite;
  logic [63:0] exmem_result, exmem_wrdata;
  logic        exmem_memwrite, exmem_memtoreg, exmem_regwrite;

  int n_vec = 0, n_bad = 0;

`ifdef FLAG_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  always #5 clk = ~clk;

  decode_execute_slice dut (
    .clk(clk), .reset(reset), .instr_if(instr_if), .pc_if(pc_if),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .alu_result_ex(alu_result_ex), .mem_fwd_data(mem_fwd_data),
    .flag_n(flag_n), .flag_v(flag_v), .ex_n(ex_n), .ex_v(ex_v),
    .br_taken(br_taken), .br_target(br_target),
    .idex_data1(idex_data1), .idex_data2(idex_data2), .idex_imm9(idex_imm9),
    .idex_imm12(idex_imm12), .idex_wrdata(idex_wrdata), .idex_rd(idex_rd),
    .idex_alusrc(idex_alusrc), .idex_aluop(idex_aluop), .idex_shamt(idex_shamt),
    .idex_setflag(idex_setflag), .idex_useshift(idex_useshift),
    .idex_memwrite(idex_memwrite), .idex_memtoreg(idex_memtoreg), .idex_regwrite(idex_regwrite),
    .exmem_result(exmem_result), .exmem_wrdata(exmem_wrdata), .exmem_rd(exmem_rd),
    .exmem_memwrite(exmem_memwrite), .exmem_memtoreg(exmem_memtoreg), .exmem_regwrite(exmem_regwrite)
  );

  typedef enum {K_NOP, K_ADDI, K_ADDS, K_SUBS, K_AND, K_EOR, K_LSR, K_LDUR, K_STUR, K_B, K_BCOND, K_CBZ} kind_e;

  typedef struct packed {
    logic [63:0] d1, d2, imm9, imm12, wrd;
    logic [4:0] rd;
    logic [1:0] src;
    logic [2:0] op;
    logic [5:0] sh;
    logic sf, us, mw, mt, rw;
  } idex_t;

  typedef struct packed {
    logic [63:0] res, wrd;
    logic [4:0] rd;
    logic mw, mt, rw;
  } exmem_t;

  idex_t       m_id = '0;
  exmem_t      m_ex = '0;
  logic [63:0] m_reg [32];

  function automatic kind_e kind(input logic [31:0] i);
    casez (i[31:21])
      11'b1001000100?: return K_ADDI;
      11'b10101011000: return K_ADDS;
      11'b11101011000: return K_SUBS;
      11'b10001010000: return K_AND;
      11'b11001010000: return K_EOR;
      11'b11010011010: return K_LSR;
      11'b11111000010: return K_LDUR;
      11'b11111000000: return K_STUR;
      11'b000101?????: return K_B;
      11'b01010100???: return K_BCOND;
      11'b10110100???: return K_CBZ;
      default:         return K_NOP;
    endcase
  endfunction

  function automatic logic [63:0] m_read(input logic [4:0] a);
    if (a == 5'd31) return 64'd0;
    if (m_id.rw && m_id.rd == a) return alu_result_ex;
    if (m_ex.rw && m_ex.rd == a) return mem_fwd_data;
    if (wb_en && wb_rd == a) return wb_data;
    return m_reg[a];
  endfunction

  function automatic idex_t m_decode(input logic [31:0] i);
    idex_t e;
    kind_e k;
    k = kind(i);
    e = '0;
    e.d1 = m_read(i[9:5]);
    e.d2 = m_read((k == K_STUR || k == K_CBZ) ? i[4:0] : i[20:16]);
    e.wrd = e.d2;
    e.imm9 = 64'($signed(i[20:12]));
    e.imm12 = 64'(i[21:10]);
    e.rd = i[4:0];
    case (k)
      K_ADDI: begin e.op = 3'd2; e.src = 2'd2; e.rw = 1'b1; end
      K_ADDS: begin e.op = 3'd2; e.sf = 1'b1; e.rw = 1'b1; end
      K_SUBS: begin e.op = 3'd3; e.sf = 1'b1; e.rw = 1'b1; end
      K_AND:  begin e.op = 3'd4; e.rw = 1'b1; end
      K_EOR:  begin e.op = 3'd6; e.rw = 1'b1; end
      K_LSR:  begin e.us = 1'b1; e.sh = i[15:10]; e.rw = 1'b1; end
      K_LDUR: begin e.op = 3'd2; e.src = 2'd1; e.mt = 1'b1; e.rw = 1'b1; end
      K_STUR: begin e.op = 3'd2; e.src = 2'd1; e.mw = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state advances with the architectural clock and clears on reset.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_id <= '0;
      m_ex <= '0;
      for (int k = 0; k < 32; k++) m_reg[k] <= '0;
    end else begin
      m_id <= m_decode(instr_if);
      m_ex <= {alu_result_ex, m_id.wrd, m_id.rd, m_id.mw, m_id.mt, m_id.rw};
      if (wb_en && wb_rd != 5'd31) m_reg[wb_rd] <= wb_data;
    end
  end

  // Compare every output against the model once per cycle, mid-cycle.
  always @(negedge clk) begin
    kind_e k;
    logic exp_tk;
    logic [63:0] exp_tg;
    k = kind(instr_if);
    exp_tk = (k == K_B) ||
             (k == K_CBZ && m_read(instr_if[4:0]) == 64'd0) ||
             (k == K_BCOND && instr_if[4:0] == 5'd11 &&
              ((BYPASS && m_id.sf) ? (ex_n != ex_v) : (flag_n != flag_v)));
    exp_tg = (k == K_B) ? pc_if + 64'($signed(instr_if[25:0])) * 64'd4
                        : pc_if + 64'($signed(instr_if[23:5])) * 64'd4;
    chk("br_taken", 64'(br_taken), 64'(exp_tk));
    if (exp_tk) chk("br_target", br_target, exp_tg);
    chk("idex_data1", idex_data1, m_id.d1);
    chk("idex_data2", idex_data2, m_id.d2);
    chk("idex_imm9", idex_imm9, m_id.imm9);
    chk("idex_imm12", idex_imm12, m_id.imm12);
    chk("idex_wrdata", idex_wrdata, m_id.wrd);
    chk("idex_rd", 64'(idex_rd), 64'(m_id.rd));
    chk("idex_alusrc", 64'(idex_alusrc), 64'(m_id.src));
    chk("idex_aluop", 64'(idex_aluop), 64'(m_id.op));
    chk("idex_shamt", 64'(idex_shamt), 64'(m_id.sh));
    chk("idex_flags", 64'({idex_setflag, idex_useshift, idex_memwrite, idex_memtoreg, idex_regwrite}),
        64'({m_id.sf, m_id.us, m_id.mw, m_id.mt, m_id.rw}));
    chk("exmem_result", exmem_result, m_ex.res);
    chk("exmem_wrdata", exmem_wrdata, m_ex.wrd);
    chk("exmem_rd", 64'(exmem_rd), 64'(m_ex.rd));
    chk("exmem_ctrl", 64'({exmem_memwrite, exmem_memtoreg, exmem_regwrite}), 64'({m_ex.mw, m_ex.mt, m_ex.rw}));
  end

  task automatic drive(input logic [31:0] i, input logic [63:0] pc, input logic [63:0] alu, input logic [63:0] mem);
    instr_if = i;
    pc_if = pc;
    alu_result_ex = alu;
    mem_fwd_data = mem;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    wb_en = 1'b0;
    ex_n = 1'b0;
    ex_v = 1'b0;
    flag_n = 1'b0;
    flag_v = 1'b0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [63:0] d);
    wb_en = 1'b1;
    wb_rd = r;
    wb_data = d;
  endtask

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [63:0] X5V = 64'h1234_5678_9ABC_DEF0;

  initial begin
    #1 reset = 1'b1;
    tick();
    tick();
    chk("rst_idex_rw", 64'(idex_regwrite), 64'd0);
    reset = 1'b0;
    wb(5'd1, 64'hAB);
    drive(NOP, 0, 0, 0);
    tick();
    drive(32'h8A01_0029, 0, 0, 0);
    tick();
    chk("x1_preload", idex_data1, 64'hAB);
    drive(32'h9100_17E1, 0, 0, 0);
    tick();
    reset = 1'b1;
    #1;
    chk("rst_idex_rd", 64'(idex_rd), 64'd0);
    chk("rst_idex_imm12", idex_imm12, 64'd0);
    chk("rst_exmem_rd", 64'(exmem_rd), 64'd0);
    chk("rst_exmem_rw", 64'(exmem_regwrite), 64'd0);
    tick();
    reset = 1'b0;
    drive(32'h8A01_0029, 0, 0, 0);
    tick();
    chk("x1_after_rst", idex_data1, 64'd0);
    drive(32'h9100_17E1, 0, 0, 0);
    tick();
    chk("addi_imm12", idex_imm12, 64'd5);
    chk("addi_alusrc", 64'(idex_alusrc), 64'd2);
    drive(32'hAB01_0022, 0, 64'd5, 0);
    tick();
    chk("adds_fwd_ex_a", idex_data1, 64'd5);
    chk("adds_fwd_ex_b", idex_data2, 64'd5);
    chk("adds_setflag", 64'(idex_setflag), 64'd1);
    drive(NOP, 0, 64'd10, 0);
    tick();
    chk("adds_exmem_res", exmem_result, 64'd10);
    chk("adds_exmem_rd", 64'(exmem_rd), 64'd2);
    drive(32'h9100_03E3, 0, 0, 0);
    tick();
    drive(NOP, 0, 64'h55, 0);
    tick();
    drive(32'h8A03_0064, 0, 0, 64'h77);
    tick();
    chk("mem_fwd_a", idex_data1, 64'h77);
    chk("mem_fwd_b", idex_data2, 64'h77);
    drive(32'h9100_03E3, 0, 0, 0);
    tick();
    drive(32'h9100_03E3, 0, 64'h99, 0);
    tick();
    drive(32'h8A03_0064, 0, 64'h11, 64'h77);
    tick();
    chk("ex_over_mem_a", idex_data1, 64'h11);
    chk("ex_over_mem_b", idex_data2, 64'h11);
    wb(5'd5, X5V);
    drive(NOP, 0, 0, 0);
    tick();
    wb(5'd6, 64'h100);
    drive(NOP, 0, 0, 0);
    tick();
    drive(32'hF81F_80C5, 0, 0, 0);
    tick();
    chk("stur_imm9", idex_imm9, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("stur_alusrc", 64'(idex_alusrc), 64'd1);
    chk("stur_mw_rw", 64'({idex_memwrite, idex_regwrite}), 64'b10);
    chk("stur_wrdata", idex_wrdata, X5V);
    chk("stur_base", idex_data1, 64'h100);
    drive(NOP, 0, 64'hF8, 0);
    tick();
    chk("stur_exmem_wrdata", exmem_wrdata, X5V);
    drive(32'hB400_0087, 64'h40, 0, 0);
    @(negedge clk);
    #1;
    chk("cbz_zero_taken", 64'(br_taken), 64'd1);
    chk("cbz_target", br_target, 64'h50);
    tick();
    wb(5'd7, 64'd1);
    drive(32'hB400_0087, 64'h40, 0, 0);
    @(negedge clk);
    #1;
    chk("cbz_bypass_nt", 64'(br_taken), 64'd0);
    tick();
    drive(32'hB400_0087, 64'h40, 0, 0);
    @(negedge clk);
    #1;
    chk("cbz_reg_nt", 64'(br_taken), 64'd0);
    tick();
    drive(32'hEB01_0028, 0, 0, 0);
    tick();
    ex_n = 1'b1;
    drive(32'h5400_004B, 64'h100, 64'd0, 0);
    @(negedge clk);
    #1;
    chk("blt_ex_flags", 64'(br_taken), 64'(BYPASS));
    tick();
    flag_n = 1'b1;
    drive(32'h5400_004B, 64'h100, 0, 0);
    @(negedge clk);
    #1;
    chk("blt_arch_taken", 64'(br_taken), 64'd1);
    chk("blt_target", br_target, 64'h108);
    tick();
    flag_n = 1'b1;
    drive(32'h5400_0040, 64'h100, 0, 0);
    @(negedge clk);
    #1;
    chk("beq_ignored", 64'(br_taken), 64'd0);
    tick();
    drive(32'h17FF_FFFF, 64'h200, 0, 0);
    @(negedge clk);
    #1;
    chk("b_back_target", br_target, 64'h1FC);
    tick();
    drive(32'hD340_102A, 0, 0, 0);
    tick();
    chk("lsr_shamt", 64'(idex_shamt), 64'd4);
    chk("lsr_useshift", 64'(idex_useshift), 64'd1);
    drive(32'hF841_00CB, 0, 0, 0);
    tick();
    chk("ldur_memtoreg", 64'(idex_memtoreg), 64'd1);
    chk("ldur_imm9", idex_imm9, 64'd16);
    drive(32'hCA06_00AC, 0, 0, 0);
    tick();
    chk("eor_aluop", 64'(idex_aluop), 64'd6);
    drive(32'hFFFF_FFFF, 0, 0, 0);
    tick();
    chk("unknown_nop", 64'({idex_regwrite, idex_memwrite, idex_aluop}), 64'd0);
    drive(NOP, 0, 0, 0);
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/decode_execute_slice.md
Name: decode_execute_slice

Overview:
- Decode and pipeline-register slice of the 5-stage LEGv8/ARMv8-subset pipeline.
- Decodes the IF/ID instruction and reads/writes the 32x64 register file.
- Forwards results from the EX and MEM stages and resolves branches in decode.
- Holds the ID/EX register and the EX/MEM register. The ALU, data memory and writeback mux are outside this block.

Parameters:
- none (XLEN fixed at 64, 32 registers)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high; clears all state
- instr_if  in  32  IF/ID instruction
- pc_if  in  64  IF/ID program counter
- wb_en  in  1  writeback enable
- wb_rd  in  5  writeback register
- wb_data  in  64  writeback data
- alu_result_ex  in  64  combinational ALU output of the instruction in EX
- mem_fwd_data  in  64  MEM-stage result (load data if memtoreg, else ALU result)
- flag_n, flag_v  in  1 each  architectural N/V flag register
- ex_n, ex_v  in  1 each  N/V produced by the ALU this cycle
- br_taken  out  1  branch taken (combinational)
- br_target  out  64  branch target (combinational)
- idex_data1, idex_data2, idex_imm9, idex_imm12, idex_wrdata  out  64 each  ID/EX operands
- idex_rd  out  5; idex_alusrc  out  2; idex_aluop  out  3; idex_shamt  out  6
- idex_setflag, idex_useshift, idex_memwrite, idex_memtoreg, idex_regwrite  out  1 each
- exmem_result, exmem_wrdata  out  64 each; exmem_rd  out  5
- exmem_memwrite, exmem_memtoreg, exmem_regwrite  out  1 each

Behaviour:
- Opcode decode (unknown opcode decodes as a NOP with all enables 0):
  - ADDI [31:22]=1001000100
  - ADDS [31:21]=10101011000
  - AND 10001010000
  - EOR 11001010000
  - SUBS 11101011000
  - LSR 11010011010
  - LDUR 11111000010
  - STUR 11111000000
  - B [31:26]=000101
  - B.cond [31:24]=01010100 (only cond=01011, LT, is honoured)
  - CBZ [31:24]=10110100
- ALUOp encoding: 000 passB, 010 add, 011 sub, 100 and, 110 xor.
- ALUSrc encoding: 00 reg, 01 imm9, 10 imm12.
- Control per instruction:
  - ADDI: add, alusrc 10, regwrite.
  - ADDS: add, setflag, regwrite.
  - SUBS: sub, setflag, regwrite.
  - AND: and, regwrite. EOR: xor, regwrite.
  - LSR: useshift, shamt=[15:10], regwrite.
  - LDUR: add, alusrc 01, memtoreg, regwrite.
  - STUR: add, alusrc 01, memwrite.
  - B, B.cond, CBZ: no writes, passB.
- Immediates: imm9 = sign-extended [20:12]; imm12 = zero-extended [21:10].
- Register fields: Rn=[9:5], Rd/Rt=[4:0], Rm=[20:16].
- Read port A uses Rn. Read port B uses Rt for STUR/CBZ, else Rm.
- Register file:
  - X31 always reads 0; writes to X31 are ignored.
  - Written on posedge when wb_en=1.
  - Same-cycle read of wb_rd returns wb_data (internal bypass).
  - All registers clear on reset.
- Forwarding, per read port with address a (a≠31):
  - if idex_regwrite && idex_rd==a, use alu_result_ex;
  - else if exmem_regwrite && exmem_rd==a, use mem_fwd_data;
  - else use the register-file value.
  - EX has priority over MEM.
- idex_wrdata = forwarded port-B data.
- No load-use stall: software inserts a NOP after loads.
- Branches (all combinational):
  - B target = pc_if + (sext(imm26[25:0])<<2).
  - B.cond and CBZ target = pc_if + (sext(imm19[23:5])<<2).
  - CBZ is taken when forwarded port-B data == 0.
  - B.LT is taken when N≠V.
  - br_target is don't-care when br_taken=0.
- ID/EX register:
  - Every output captures its decode value on posedge.
  - Latency 1 cycle; no stall or flush inputs.
- EX/MEM register, on posedge:
  - exmem_result ← alu_result_ex
  - exmem_wrdata ← idex_wrdata
  - exmem_rd ← idex_rd
  - exmem_memwrite/memtoreg/regwrite ← idex_memwrite/memtoreg/regwrite
- Reset:
  - all idex_*/exmem_* outputs and registers go to 0 immediately, acting as NOP bubbles;
  - reset asserted mid-operation discards in-flight instructions.

Optional Feature:
- FLAG_BYPASS_EN defined: B.LT uses ex_n/ex_v when idex_setflag=1, else flag_n/flag_v.
- FLAG_BYPASS_EN undefined: B.LT always uses flag_n/flag_v. Software must leave one instruction between the flag-setter and B.cond.

Decomposition:
- Package decode_pkg holds:
  - opcode constants;
  - ALUOp and ALUSrc enums;
  - a control-bundle struct;
  - the zero-register index 31.
- One sub-module, regfile_32x64: two read ports, one write port, async reset, write bypass.
- Decode, forwarding, branch logic and both pipeline registers live in the top.

Test Plan:
- Reset:
  - preload X1 via wb, assert reset mid-run;
  - all idex/exmem outputs are 0; reading X1 then returns 0.
- ADDI X1,X31,#5, then ADDS X2,X1,X1 back-to-back:
  - idex_data1 for ADDS = alu_result_ex (5);
  - with alu=10 the next exmem_result=10, exmem_rd=2.
- MEM forward:
  - exmem_rd=3 regwrite and mem_fwd_data=0x77 while decoding AND X4,X3,X3;
  - both operands = 0x77;
  - when EX also writes X3=0x11, EX (0x11) wins.
- STUR X5,[X6,#-8]:
  - imm9 = 0xFFFF_FFFF_FFFF_FFF8, alusrc 01, memwrite=1, regwrite=0;
  - idex_wrdata = X5 value.
- CBZ X7,#4 at pc=0x40:
  - X7=0 gives br_taken=1, target 0x50;
  - X7=1 gives br_taken=0.
- B.LT with idex_setflag=1, ex_n=1, ex_v=0, flag_n=flag_v=0:
  - taken with FLAG_BYPASS_EN defined;
  - not taken without it.
